screen_state_ctrl: RTL and testbench

- Game-board state engine; sits directly upstream of the win checker.
- Owns the ScreenValues register that the win checker consumes and takes the checker's Buzz back as its win input.
- Scrambles a new board from a free-running LFSR, moves a cursor from push-buttons, and toggles the cursor cell plus its neighbours (1-D lights-out).
- Freezes the board once the win is reported.

---
 rtl/screen_state_ctrl.sv | 141 ++++++++++++++
 tb/tb_screen_state_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/screen_state_ctrl.sv
// Lights-out board engine: scrambles a board from an LFSR, moves a cursor,
// toggles cursor neighbourhoods and freezes once the win checker reports.
module screen_state_ctrl #(
  parameter int                    NumberOfBits = 31,
  parameter int                    CursorBits   = 5,
  parameter logic [NumberOfBits:0] TAPS         = 32'h8020_0003,
  parameter logic [NumberOfBits:0] SEED         = 32'h0000_0001
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    btn_left,
  input  logic                    btn_right,
  input  logic                    btn_sel,
  input  logic                    btn_start,
  input  logic                    win,
  output logic [NumberOfBits:0]   ScreenValues,
  output logic [CursorBits-1:0]   cursor,
  output logic [15:0]             moves,
  output logic                    playing,
  output logic                    won,
  output logic                    clear_win
);

  localparam logic [NumberOfBits:0] LfsrInit =
    (SEED == '0) ? {{NumberOfBits{1'b0}}, 1'b1} : SEED;
  localparam logic [CursorBits-1:0] CursorMax =
    CursorBits'(NumberOfBits);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    PLAY,
    WON
  } state_t;

  state_t state_q, state_d;

  logic [NumberOfBits:0]   board_q, board_d;
  logic [CursorBits-1:0]   cursor_q, cursor_d;
  logic [15:0]             moves_q, moves_d;
  logic [NumberOfBits:0]   lfsr;
  logic [NumberOfBits+2:0] wide;
  logic [NumberOfBits:0]   mask;

  logic [3:0] btn_raw;
  logic [3:0] sync1, sync2, prev;
  logic [3:0] pulse;
  logic       left_p, right_p, sel_p, start_p;

  assign btn_raw = {btn_start, btn_sel, btn_right, btn_left};
  assign pulse   = sync2 & ~prev;
  assign left_p  = pulse[0];
  assign right_p = pulse[1];
  assign sel_p   = pulse[2];
  assign start_p = pulse[3];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr <= LfsrInit;
    end else begin
      lfsr <= (lfsr >> 1) ^ (lfsr[0] ? TAPS : '0);
    end
  end

  // Three-bit window centred on the cursor; the ends fall off the board.
  assign wide = {{NumberOfBits{1'b0}}, 3'b111} << cursor_q;
  assign mask = wide[NumberOfBits+1:1];

  always_comb begin
    state_d   = state_q;
    board_d   = board_q;
    cursor_d  = cursor_q;
    moves_d   = moves_q;
    clear_win = 1'b0;
    playing   = 1'b0;
    won       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_p) state_d = LOAD;
      end
      LOAD: begin
        clear_win = 1'b1;
        board_d   = lfsr;
        cursor_d  = '0;
        moves_d   = '0;
        state_d   = PLAY;
      end
      PLAY: begin
        playing = 1'b1;
        if (start_p) begin
          state_d = LOAD;
        end else if (win) begin
          state_d = WON;
        end else if (sel_p) begin
          board_d = board_q ^ mask;
          if (moves_q != 16'hFFFF) moves_d = moves_q + 16'd1;
        end else if (left_p && !right_p) begin
          if (cursor_q != '0) cursor_d = cursor_q - 1'b1;
        end else if (right_p && !left_p) begin
          if (cursor_q != CursorMax) cursor_d = cursor_q + 1'b1;
        end
      end
      WON: begin
        won = 1'b1;
        if (start_p) state_d = LOAD;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      board_q  <= '0;
      cursor_q <= '0;
      moves_q  <= '0;
    end else begin
      state_q  <= state_d;
      board_q  <= board_d;
      cursor_q <= cursor_d;
      moves_q  <= moves_d;
    end
  end

  assign ScreenValues = board_q;
  assign cursor       = cursor_q;
  assign moves        = moves_q;

endmodule

// File: tb/tb_screen_state_ctrl.sv
// Directed bench for screen_state_ctrl: reset, load, toggles, cursor limits,
// win freeze and mid-game reset.
module tb_screen_state_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  btns = '0;
  logic        win = 1'b0;
  logic [31:0] ScreenValues;
  logic [4:0]  cursor;
  logic [15:0] moves;
  logic        playing, won, clear_win;

  int checks = 0;
  int passed = 0;

  logic [31:0] m_lfsr;
  logic [31:0] exp_b;
  logic [15:0] exp_m;

  localparam logic [3:0] L = 4'b0001;
  localparam logic [3:0] R = 4'b0010;
  localparam logic [3:0] S = 4'b0100;
  localparam logic [3:0] T = 4'b1000;

  screen_state_ctrl dut (
    .clk(clk),
    .reset(reset),
    .btn_left(btns[0]),
    .btn_right(btns[1]),
    .btn_sel(btns[2]),
    .btn_start(btns[3]),
    .win(win),
    .ScreenValues(ScreenValues),
    .cursor(cursor),
    .moves(moves),
    .playing(playing),
    .won(won),
    .clear_win(clear_win)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) m_lfsr <= 32'h1;
    else m_lfsr <= (m_lfsr >> 1) ^ (m_lfsr[0] ? 32'h8020_0003 : 32'h0);
  end

  task automatic press(input logic [3:0] m);
    @(negedge clk);
    btns = m;
    @(negedge clk);
    btns = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic start_game();
    logic [31:0] s;
    @(negedge clk);
    btns = T;
    @(negedge clk);
    btns = '0;
    @(negedge clk);
    checks++;
    if (clear_win !== 1'b0)
      $display("FAIL early_clear got %b want 0", clear_win);
    else passed++;
    @(negedge clk);
    s = m_lfsr;
    checks++;
    if (clear_win !== 1'b1)
      $display("FAIL load_clear got %b want 1", clear_win);
    else passed++;
    checks++;
    if (s === 32'h0) $display("FAIL lfsr_zero got %h want nonzero", s);
    else passed++;
    @(negedge clk);
    checks++;
    if (ScreenValues !== s)
      $display("FAIL load_board got %h want %h", ScreenValues, s);
    else passed++;
    checks++;
    if ({clear_win, playing, won} !== 3'b010)
      $display("FAIL load_flags got %b want 010", {clear_win, playing, won});
    else passed++;
    checks++;
    if ({cursor, moves} !== 21'h0)
      $display("FAIL load_cm got %0d/%0d want 0/0", cursor, moves);
    else passed++;
    exp_b = s;
    exp_m = 16'h0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({ScreenValues, cursor, moves} !== 53'h0)
      $display("FAIL reset_data got %h/%0d/%0d want 0", ScreenValues, cursor, moves);
    else passed++;
    checks++;
    if ({playing, won, clear_win} !== 3'b000)
      $display("FAIL reset_flags got %b want 000", {playing, won, clear_win});
    else passed++;
    reset = 1'b0;
    press(S);
    press(R);
    checks++;
    if ({ScreenValues, cursor, playing} !== 38'h0)
      $display("FAIL idle_ignore got %h/%0d want 0/0", ScreenValues, cursor);
    else passed++;
  endtask

  task automatic test_toggle();
    start_game();
    press(S);
    exp_b ^= 32'h3;
    checks++;
    if (ScreenValues !== exp_b || moves !== 16'd1)
      $display("FAIL sel0 got %h/%0d want %h/1", ScreenValues, moves, exp_b);
    else passed++;
    repeat (3) press(R);
    press(S);
    exp_b ^= 32'h1C;
    checks++;
    if (ScreenValues !== exp_b || moves !== 16'd2 || cursor !== 5'd3)
      $display("FAIL sel3 got %h/%0d/%0d want %h/2/3", ScreenValues, moves, cursor, exp_b);
    else passed++;
    @(negedge clk);
    btns = S;
    repeat (20) @(negedge clk);
    btns = '0;
    repeat (3) @(negedge clk);
    exp_b ^= 32'h1C;
    checks++;
    if (ScreenValues !== exp_b || moves !== 16'd3)
      $display("FAIL hold got %h/%0d want %h/3", ScreenValues, moves, exp_b);
    else passed++;
  endtask

  task automatic test_boundaries();
    repeat (40) press(R);
    checks++;
    if (cursor !== 5'd31) $display("FAIL right_sat got %0d want 31", cursor);
    else passed++;
    press(S);
    exp_b ^= 32'hC000_0000;
    checks++;
    if (ScreenValues !== exp_b)
      $display("FAIL sel31 got %h want %h", ScreenValues, exp_b);
    else passed++;
    repeat (40) press(L);
    checks++;
    if (cursor !== 5'd0) $display("FAIL left_sat got %0d want 0", cursor);
    else passed++;
    press(R);
    press(L | R);
    checks++;
    if (cursor !== 5'd1) $display("FAIL left_right got %0d want 1", cursor);
    else passed++;
    @(negedge clk);
    force dut.moves_q = 16'hFFFE;
    @(posedge clk);
    #1 release dut.moves_q;
    @(negedge clk);
    press(S);
    exp_b ^= 32'h7;
    checks++;
    if (moves !== 16'hFFFF || ScreenValues !== exp_b)
      $display("FAIL moves_top got %h/%h want ffff/%h", moves, ScreenValues, exp_b);
    else passed++;
    press(S);
    exp_b ^= 32'h7;
    checks++;
    if (moves !== 16'hFFFF) $display("FAIL moves_sat got %h want ffff", moves);
    else passed++;
  endtask

  task automatic test_win();
    logic [4:0]  c;
    logic [15:0] m;
    start_game();
    press(R);
    press(S);
    exp_b ^= 32'h7;
    c = cursor;
    m = moves;
    @(negedge clk);
    btns = S;
    @(negedge clk);
    btns = '0;
    @(negedge clk);
    win = 1'b1;
    @(negedge clk);
    win = 1'b0;
    checks++;
    if ({won, playing} !== 2'b10)
      $display("FAIL win_state got %b want 10", {won, playing});
    else passed++;
    checks++;
    if (ScreenValues !== exp_b || moves !== m)
      $display("FAIL win_prio got %h/%0d want %h/%0d", ScreenValues, moves, exp_b, m);
    else passed++;
    press(S);
    press(L);
    press(R);
    checks++;
    if (ScreenValues !== exp_b || moves !== m || cursor !== c || won !== 1'b1)
      $display("FAIL frozen got %h/%0d/%0d want %h/%0d/%0d",
               ScreenValues, moves, cursor, exp_b, m, c);
    else passed++;
    start_game();
  endtask

  task automatic test_mid_reset();
    repeat (5) press(S);
    checks++;
    if (moves !== 16'd5) $display("FAIL five_moves got %0d want 5", moves);
    else passed++;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({ScreenValues, cursor, moves, playing, won, clear_win} !== 56'h0)
      $display("FAIL mid_reset got %h/%0d/%0d/%b%b%b want all 0",
               ScreenValues, cursor, moves, playing, won, clear_win);
    else passed++;
    reset = 1'b0;
    win = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if ({playing, won, clear_win} !== 3'b000)
      $display("FAIL idle_win got %b want 000", {playing, won, clear_win});
    else passed++;
    win = 1'b0;
  endtask

  initial begin
    test_reset();
    test_toggle();
    test_boundaries();
    test_win();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
